io_input_conditioner: RTL and testbench

- Board-input front end sitting directly upstream of the CPU top level and its data memory MMIO (switch read, button input).
- Synchronises the 16 raw slide switches and the raw push button into `clk`, debounces them, and produces:
  - clean levels;
  - edge pulses stretched long enough for the divided CPU clock (`clk`/4) to sample;
  - a wrapping press counter that software can poll.

---
 rtl/io_input_conditioner_pkg.sv | 16 +
 rtl/io_input_conditioner_pulse_stretcher.sv | 24 ++
 rtl/io_input_conditioner.sv | 206 ++++++++++++++++++++
 tb/tb_io_input_conditioner.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/io_input_conditioner_pkg.sv
// Shared types and defaults for the board-input conditioner.
package io_input_conditioner_pkg;

  typedef enum logic [1:0] {
    BTN_IDLE        = 2'd0,
    BTN_PRESS_CHK   = 2'd1,
    BTN_PRESSED     = 2'd2,
    BTN_RELEASE_CHK = 2'd3
  } btn_state_t;

  // 10 ms sample interval at 100 MHz
  localparam int DEF_SAMPLE_DIV    = 1000000;
  // long enough for a clk/4 CPU clock to see every event
  localparam int DEF_PULSE_STRETCH = 4;

endpackage

// File: rtl/io_input_conditioner_pulse_stretcher.sv
// Load-on-event down-counter: holds pulse high for STRETCH cycles after the
// most recent event; a new event mid-stretch just reloads the count.
module io_input_conditioner_pulse_stretcher #(
  parameter int STRETCH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic ev,
  output logic pulse
);
  localparam int CW = $clog2(STRETCH + 1);

  logic [CW-1:0] cnt_q;

  // reload on event, otherwise count down to zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                cnt_q <= '0;
    else if (ev)            cnt_q <= CW'(STRETCH);
    else if (cnt_q != '0)   cnt_q <= cnt_q - CW'(1);
  end

  assign pulse = (cnt_q != '0);

endmodule

// File: rtl/io_input_conditioner.sv
// Board-input front end: synchronise, debounce and stretch events for the
// slide switches and push button, plus a wrapping press counter.
// Optional build macro INPUT_AUTO_REPEAT_EN adds button auto-repeat.
module io_input_conditioner
  import io_input_conditioner_pkg::*;
#(
  parameter int SW_WIDTH      = 16,
  parameter int SAMPLE_DIV    = DEF_SAMPLE_DIV,
  parameter int BTN_TICKS     = 2,
  parameter int PULSE_STRETCH = DEF_PULSE_STRETCH
`ifdef INPUT_AUTO_REPEAT_EN
  ,
  parameter int REPEAT_DELAY  = 50,
  parameter int REPEAT_PERIOD = 10
`endif
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SW_WIDTH-1:0] sw_raw,
  input  logic                btn_raw,
  output logic [SW_WIDTH-1:0] sw_clean,
  output logic                sw_changed,
  output logic                btn_level,
  output logic                btn_press,
  output logic                btn_release,
  output logic [7:0]          press_count
);
  localparam int TW = $clog2(SAMPLE_DIV);
  localparam int CW = $clog2(BTN_TICKS + 1);

  logic [SW_WIDTH-1:0] sw_meta, sw_sync;
  logic                btn_meta, btn_sync;
  logic [TW-1:0]       tcnt_q;
  logic                tick;
  logic [SW_WIDTH-1:0] sw_upd;

  btn_state_t    state_q, state_n;
  logic [CW-1:0] cnt_q, cnt_n, cnt_inc;
  logic          press_ev, rel_ev, rep_ev;

  // two-flop synchronisers on every raw input
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_meta  <= '0;
      sw_sync  <= '0;
      btn_meta <= 1'b0;
      btn_sync <= 1'b0;
    end else begin
      sw_meta  <= sw_raw;
      sw_sync  <= sw_meta;
      btn_meta <= btn_raw;
      btn_sync <= btn_meta;
    end
  end

  // sample tick: one cycle in every SAMPLE_DIV
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       tcnt_q <= '0;
    else if (tick) tcnt_q <= '0;
    else           tcnt_q <= tcnt_q + TW'(1);
  end

  assign tick = (tcnt_q == TW'(SAMPLE_DIV - 1));

  // per-bit switch filter: accept a level seen on three consecutive samples
  for (genvar g = 0; g < SW_WIDTH; g++) begin : g_sw
    logic [1:0] hist_q;
    logic       clean_q;

    assign sw_upd[g] = tick && (hist_q[1] == hist_q[0]) &&
                       (hist_q[0] == sw_sync[g]) && (sw_sync[g] != clean_q);

    // shift history on tick; update clean level when all three agree
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        hist_q  <= '0;
        clean_q <= 1'b0;
      end else begin
        if (tick)      hist_q  <= {hist_q[0], sw_sync[g]};
        if (sw_upd[g]) clean_q <= sw_sync[g];
      end
    end

    assign sw_clean[g] = clean_q;
  end

  assign cnt_inc = cnt_q + CW'(1);

  // button FSM state, agreement counter and press counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= BTN_IDLE;
      cnt_q       <= '0;
      press_count <= '0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      if (press_ev || rep_ev) press_count <= press_count + 8'd1;
    end
  end

  // button next-state: only advances on sample ticks
  always_comb begin
    state_n  = state_q;
    cnt_n    = cnt_q;
    press_ev = 1'b0;
    rel_ev   = 1'b0;
    if (tick) begin
      case (state_q)
        BTN_IDLE: begin
          if (btn_sync) begin
            state_n = BTN_PRESS_CHK;
            cnt_n   = CW'(1);
          end
        end
        BTN_PRESS_CHK: begin
          if (!btn_sync) begin
            state_n = BTN_IDLE;
            cnt_n   = '0;
          end else if (cnt_inc == CW'(BTN_TICKS)) begin
            state_n  = BTN_PRESSED;
            cnt_n    = '0;
            press_ev = 1'b1;
          end else begin
            cnt_n = cnt_inc;
          end
        end
        BTN_PRESSED: begin
          if (!btn_sync) begin
            state_n = BTN_RELEASE_CHK;
            cnt_n   = CW'(1);
          end
        end
        BTN_RELEASE_CHK: begin
          if (btn_sync) begin
            state_n = BTN_PRESSED;
            cnt_n   = '0;
          end else if (cnt_inc == CW'(BTN_TICKS)) begin
            state_n = BTN_IDLE;
            cnt_n   = '0;
            rel_ev  = 1'b1;
          end else begin
            cnt_n = cnt_inc;
          end
        end
      endcase
    end
  end

`ifdef INPUT_AUTO_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);

  logic [RW-1:0] rep_q, rep_n, rep_inc;
  logic          rep_ph_q, rep_ph_n;   // 0: waiting initial delay, 1: repeating

  assign rep_inc = rep_q + RW'(1);

  // repeat counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rep_q    <= '0;
      rep_ph_q <= 1'b0;
    end else begin
      rep_q    <= rep_n;
      rep_ph_q <= rep_ph_n;
    end
  end

  // count held ticks in PRESSED; cleared whenever the hold is broken
  always_comb begin
    rep_n    = rep_q;
    rep_ph_n = rep_ph_q;
    rep_ev   = 1'b0;
    if (state_q != BTN_PRESSED) begin
      rep_n    = '0;
      rep_ph_n = 1'b0;
    end else if (tick) begin
      if (!btn_sync) begin
        rep_n    = '0;
        rep_ph_n = 1'b0;
      end else if (rep_inc == (rep_ph_q ? RW'(REPEAT_PERIOD) : RW'(REPEAT_DELAY))) begin
        rep_n    = '0;
        rep_ph_n = 1'b1;
        rep_ev   = 1'b1;
      end else begin
        rep_n = rep_inc;
      end
    end
  end
`else
  assign rep_ev = 1'b0;
`endif

  assign btn_level = (state_q == BTN_PRESSED) || (state_q == BTN_RELEASE_CHK);

  io_input_conditioner_pulse_stretcher #(.STRETCH(PULSE_STRETCH)) u_chg_str (
    .clk(clk), .rst(rst), .ev(|sw_upd), .pulse(sw_changed));

  io_input_conditioner_pulse_stretcher #(.STRETCH(PULSE_STRETCH)) u_prs_str (
    .clk(clk), .rst(rst), .ev(press_ev | rep_ev), .pulse(btn_press));

  io_input_conditioner_pulse_stretcher #(.STRETCH(PULSE_STRETCH)) u_rel_str (
    .clk(clk), .rst(rst), .ev(rel_ev), .pulse(btn_release));

endmodule

// File: tb/tb_io_input_conditioner.sv
// Directed bench for io_input_conditioner with a fast sample tick.
module tb_io_input_conditioner;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] sw_raw;
  logic        btn_raw;
  logic [15:0] sw_clean;
  logic        sw_changed, btn_level, btn_press, btn_release;
  logic [7:0]  press_count;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int press_hi, rel_hi, chg_hi, press_rise;
  logic prev_press;

  always #5 clk = ~clk;

  io_input_conditioner #(
    .SW_WIDTH(16), .SAMPLE_DIV(4), .BTN_TICKS(2), .PULSE_STRETCH(4)
`ifdef INPUT_AUTO_REPEAT_EN
    , .REPEAT_DELAY(3), .REPEAT_PERIOD(2)
`endif
  ) dut (
    .clk(clk), .rst(rst), .sw_raw(sw_raw), .btn_raw(btn_raw),
    .sw_clean(sw_clean), .sw_changed(sw_changed), .btn_level(btn_level),
    .btn_press(btn_press), .btn_release(btn_release), .press_count(press_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    press_hi = 0; rel_hi = 0; chg_hi = 0; press_rise = 0;
  endtask

  // advance n cycles, sampling 1 time unit after each rising edge
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (btn_press && !prev_press) press_rise++;
      prev_press = btn_press;
      press_hi += int'(btn_press);
      rel_hi   += int'(btn_release);
      chg_hi   += int'(sw_changed);
    end
  endtask

  // stop where the next-but-two edge is a sample tick (ticks at cyc % 4 == 0)
  task automatic align();
    while ((cyc + 3) % 4 != 0) run(1);
  endtask

  initial begin
    int exp_cnt;
    prev_press = 1'b0;
    clr();

    // 1: reset with inputs already active
    rst = 1'b1; sw_raw = 16'hFFFF; btn_raw = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("reset_outputs", 32'({sw_clean, sw_changed, btn_level, btn_press, btn_release, press_count}), 32'h0);
    end
    rst = 1'b0; cyc = 0;
    run(14);
    check("pwrup_sw_clean", 32'(sw_clean), 32'hFFFF);
    run(10);
    check("pwrup_press_hi", 32'(press_hi), 32'd4);
    check("pwrup_press_rise", 32'(press_rise), 32'd1);
    check("pwrup_press_count", 32'(press_count), 32'd1);
    check("pwrup_chg_hi", 32'(chg_hi), 32'd4);
    check("pwrup_level", 32'(btn_level), 32'd1);

    // release everything
    clr(); btn_raw = 1'b0; sw_raw = 16'h0000;
    run(30);
    check("rel_level", 32'(btn_level), 32'd0);
    check("rel_hi", 32'(rel_hi), 32'd4);
    check("rel_sw_clean", 32'(sw_clean), 32'h0);
    check("rel_chg_hi", 32'(chg_hi), 32'd4);
    check("rel_count", 32'(press_count), 32'd1);

    // 2: short glitch on bit 3
    clr(); sw_raw = 16'h0008;
    run(3);
    sw_raw = 16'h0000;
    run(30);
    check("glitch_sw_clean", 32'(sw_clean), 32'h0);
    check("glitch_chg_hi", 32'(chg_hi), 32'd0);

    // 3: clean press with a simultaneous switch change
    clr(); btn_raw = 1'b1; sw_raw = 16'hA5C3;
    run(10);
    check("press_level_up", 32'(btn_level), 32'd1);
    run(30);
    check("press_hi", 32'(press_hi), 32'd4);
    check("press_rise", 32'(press_rise), 32'd1);
    check("press_count2", 32'(press_count), 32'd2);
    check("press_sw_clean", 32'(sw_clean), 32'hA5C3);
    check("press_chg_hi", 32'(chg_hi), 32'd4);
    clr(); btn_raw = 1'b0;
    run(10);
    check("release_level_dn", 32'(btn_level), 32'd0);
    run(10);
    check("release_hi", 32'(rel_hi), 32'd4);
    check("release_no_press", 32'(press_hi), 32'd0);

    // mid-operation asynchronous reset
    btn_raw = 1'b1;
    run(10);
    check("midrst_level_pre", 32'(btn_level), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("midrst_outputs", 32'({sw_clean, sw_changed, btn_level, btn_press, btn_release, press_count}), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0; cyc = 0; prev_press = 1'b0; clr();
    run(24);
    check("midrst_count", 32'(press_count), 32'd1);
    check("midrst_sw_clean", 32'(sw_clean), 32'hA5C3);
    check("midrst_press_hi", 32'(press_hi), 32'd4);
    btn_raw = 1'b0;
    run(20);
    check("midrst_level_dn", 32'(btn_level), 32'd0);

    // 4: bounce seen on exactly one tick, twice
    clr();
    for (int k = 0; k < 2; k++) begin
      align();
      btn_raw = 1'b1;
      run(4);
      btn_raw = 1'b0;
      run(20);
    end
    check("bounce_rise", 32'(press_rise), 32'd0);
    check("bounce_count", 32'(press_count), 32'd1);
    check("bounce_level", 32'(btn_level), 32'd0);

    // 5: counter wrap
    clr();
    for (int k = 0; k < 254; k++) begin
      btn_raw = 1'b1; run(16);
      btn_raw = 1'b0; run(16);
    end
    check("wrap_count_255", 32'(press_count), 32'd255);
    btn_raw = 1'b1; run(16);
    btn_raw = 1'b0; run(16);
    check("wrap_count_0", 32'(press_count), 32'd0);
    check("wrap_rise", 32'(press_rise), 32'd255);
    check("wrap_press_hi", 32'(press_hi), 32'd1020);

    // 6: long hold, 12 ticks spent in PRESSED
`ifdef INPUT_AUTO_REPEAT_EN
    exp_cnt = 6;
`else
    exp_cnt = 1;
`endif
    clr();
    align();
    btn_raw = 1'b1;
    run(55);
    btn_raw = 1'b0;
    run(20);
    check("hold_count", 32'(press_count), 32'(exp_cnt));
    check("hold_rise", 32'(press_rise), 32'(exp_cnt));
    check("hold_rel_hi", 32'(rel_hi), 32'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
